// File: rtl/timedelay_array_if.sv
// Bus for the multi-channel time-delay block: raw status inputs and
// per-channel clears in, threshold taps and qualified outputs back.
interface timedelay_array_if #(
   parameter int CHANNELS = 4,
   parameter int TAPS     = 6
);
   logic [CHANNELS-1:0]      in;
   logic [CHANNELS-1:0]      clr;
   logic [CHANNELS*TAPS-1:0] tap;
   logic [CHANNELS-1:0]      out;
   logic [CHANNELS-1:0]      rise;
   logic [CHANNELS-1:0]      fall;

   modport master (output in, clr, input tap, out, rise, fall);
   modport slave  (input in, clr, output tap, out, rise, fall);
endinterface

// File: rtl/timedelay_array.sv
// Multi-channel time-delay / power-good qualifier. Each channel counts
// consecutive high clocks, drives evenly spaced threshold taps, and a
// glitch-filtered output that sets at full delay and clears only after
// a programmable low-hold time.

// One independent channel.
module timedelay_chan #(
   parameter int TAPS      = 6,
   parameter int TAP_STEP  = 5,
   parameter int OFF_DELAY = 5,
   parameter int CNT_W     = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in,
   input  logic            clr,
   output logic [TAPS-1:0] tap,
   output logic            out,
   output logic            rise,
   output logic            fall
);
   localparam logic [CNT_W-1:0] MAX   = CNT_W'(TAPS * TAP_STEP);
   localparam logic [CNT_W-1:0] OFF_D = CNT_W'(OFF_DELAY);

   typedef enum logic [1:0] {S_OFF, S_ON, S_HOLD} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] offcnt;

   // Next high-time count: saturate at MAX, any low sample restarts it.
   always_comb begin
      cnt_nxt = '0;
      if (!clr && in)
         cnt_nxt = (cnt == MAX) ? MAX : cnt + CNT_W'(1);
   end

   // High-time counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt <= '0;
      else     cnt <= cnt_nxt;
   end

   // Taps decode straight off the registered count so they clear with reset.
   for (genvar k = 0; k < TAPS; k++) begin : g_tap
      assign tap[k] = (cnt >= CNT_W'((k + 1) * TAP_STEP));
   end

   // Qualification FSM with registered out/rise/fall; clr wins and never pulses fall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_OFF;
         offcnt <= '0;
         out    <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (clr) begin
            state  <= S_OFF;
            offcnt <= '0;
            out    <= 1'b0;
         end else begin
            case (state)
               S_OFF: begin
                  if (cnt_nxt == MAX) begin
                     state <= S_ON;
                     out   <= 1'b1;
                     rise  <= 1'b1;
                  end
               end
               S_ON: begin
                  if (!in) begin
                     if (OFF_DELAY > 0) begin
                        state  <= S_HOLD;
                        offcnt <= CNT_W'(1);
                     end else begin
                        state <= S_OFF;
                        out   <= 1'b0;
                        fall  <= 1'b1;
                     end
                  end
               end
               S_HOLD: begin
                  if (in) begin
                     // Input came back before the hold expired: stay on, taps re-ramp.
                     state  <= S_ON;
                     offcnt <= '0;
                  end else if (offcnt == OFF_D) begin
                     state  <= S_OFF;
                     offcnt <= '0;
                     out    <= 1'b0;
                     fall   <= 1'b1;
                  end else begin
                     offcnt <= offcnt + CNT_W'(1);
                  end
               end
               default: begin
                  state  <= S_OFF;
                  offcnt <= '0;
                  out    <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// Top: one channel instance per input, taps packed channel-major.
module timedelay_array #(
   parameter int CHANNELS  = 4,
   parameter int TAPS      = 6,
   parameter int TAP_STEP  = 5,
   parameter int OFF_DELAY = 5,
   parameter int CNT_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   timedelay_array_if.slave  bus
);
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      timedelay_chan #(
         .TAPS      (TAPS),
         .TAP_STEP  (TAP_STEP),
         .OFF_DELAY (OFF_DELAY),
         .CNT_W     (CNT_W)
      ) u_chan (
         .clk  (clk),
         .rst  (rst),
         .in   (bus.in[i]),
         .clr  (bus.clr[i]),
         .tap  (bus.tap[i*TAPS +: TAPS]),
         .out  (bus.out[i]),
         .rise (bus.rise[i]),
         .fall (bus.fall[i])
      );
   end
endmodule

// File: tb/tb_timedelay_array.sv
// Directed bench for timedelay_array with default parameters
// (4 channels, 6 taps every 5 clocks, 5-clock low hold).
module tb_timedelay_array;
   localparam int CH = 4;
   localparam int TP = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;

   timedelay_array_if #(.CHANNELS(CH), .TAPS(TP)) bus ();

   timedelay_array #(
      .CHANNELS (CH), .TAPS (TP), .TAP_STEP (5), .OFF_DELAY (5), .CNT_W (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [TP-1:0] taps(input int ch);
      return bus.tap[ch*TP +: TP];
   endfunction

   // Expected taps after e consecutive high edges from a zero count.
   function automatic logic [TP-1:0] ramp(input int e);
      int n = e / 5;
      if (n > TP) n = TP;
      return TP'((1 << n) - 1);
   endfunction

   initial begin
      bus.in  = '0;
      bus.clr = '0;
      #1;
      check("reset_tap",  32'(bus.tap),  32'h0);
      check("reset_out",  32'(bus.out),  32'h0);
      check("reset_rise", 32'(bus.rise), 32'h0);
      check("reset_fall", 32'(bus.fall), 32'h0);

      // Async reset mid-ramp.
      tick();
      rst = 1'b0;
      bus.in = 4'hF;
      for (int e = 0; e < 8; e++) tick();
      check("pre_rst_tap0", 32'(taps(0)), 32'h01);
      #2 rst = 1'b1;
      #1;
      check("async_rst_tap", 32'(bus.tap), 32'h0);
      check("async_rst_out", 32'(bus.out), 32'h0);
      tick();
      bus.in = '0;
      rst = 1'b0;
      tick();
      tick();
      check("post_rst_tap", 32'(bus.tap), 32'h0);
      check("post_rst_out", 32'(bus.out), 32'h0);

      // Ramp glitch on channel 0.
      bus.in = 4'h1;
      for (int e = 1; e <= 12; e++) begin
         tick();
         check($sformatf("glitch_out_%0d", e), 32'(bus.out[0]), 32'h0);
      end
      check("glitch_tap_e12", 32'(taps(0)), 32'h03);
      bus.in = 4'h0;
      tick();
      check("glitch_tap_low", 32'(taps(0)), 32'h00);
      bus.in = 4'h1;
      for (int e = 1; e <= 5; e++) begin
         tick();
         check($sformatf("glitch2_out_%0d", e), 32'(bus.out[0]), 32'h0);
      end
      check("glitch_tap_re", 32'(taps(0)), 32'h01);

      // Full ramp on channel 0 from zero.
      bus.in = 4'h0;
      tick();
      bus.in = 4'h1;
      for (int e = 1; e <= 40; e++) begin
         tick();
         if (e % 5 == 0) check($sformatf("ramp_tap_%0d", e), 32'(taps(0)), 32'(ramp(e)));
         if (e == 29) check("ramp_out_29", 32'(bus.out[0]), 32'h0);
         if (e == 30) begin
            check("ramp_out_30",  32'(bus.out[0]),  32'h1);
            check("ramp_rise_30", 32'(bus.rise[0]), 32'h1);
         end
         if (e == 31) check("ramp_rise_31", 32'(bus.rise[0]), 32'h0);
      end
      check("ramp_out_sat", 32'(bus.out[0]), 32'h1);

      // Hysteresis: short drop held through HOLD, then a long drop.
      bus.in = 4'h0;
      for (int e = 1; e <= 3; e++) begin
         tick();
         check($sformatf("hold_out_%0d", e), 32'(bus.out[0]), 32'h1);
         check($sformatf("hold_tap_%0d", e), 32'(taps(0)), 32'h0);
      end
      bus.in = 4'h1;
      for (int e = 1; e <= 5; e++) begin
         tick();
         check($sformatf("rehi_out_%0d", e),  32'(bus.out[0]),  32'h1);
         check($sformatf("rehi_rise_%0d", e), 32'(bus.rise[0]), 32'h0);
      end
      check("rehi_tap", 32'(taps(0)), 32'h01);
      bus.in = 4'h0;
      for (int e = 1; e <= 7; e++) begin
         tick();
         check($sformatf("off_out_%0d", e),  32'(bus.out[0]),  (e >= 6) ? 32'h0 : 32'h1);
         check($sformatf("off_fall_%0d", e), 32'(bus.fall[0]), (e == 6) ? 32'h1 : 32'h0);
         check($sformatf("off_rise_%0d", e), 32'(bus.rise[0]), 32'h0);
      end

      // clr while in HOLD.
      bus.in = 4'h1;
      for (int e = 1; e <= 30; e++) tick();
      check("clr_pre_on", 32'(bus.out[0]), 32'h1);
      bus.in = 4'h0;
      tick();
      tick();
      check("clr_in_hold", 32'(bus.out[0]), 32'h1);
      bus.clr = 4'h1;
      tick();
      check("clr_out",  32'(bus.out[0]),  32'h0);
      check("clr_fall", 32'(bus.fall[0]), 32'h0);
      bus.clr = 4'h0;
      bus.in  = 4'h1;
      tick();
      check("clr_fall_next", 32'(bus.fall[0]), 32'h0);
      for (int e = 2; e <= 29; e++) tick();
      check("clr_reramp_29", 32'(bus.out[0]), 32'h0);
      tick();
      check("clr_reramp_30", 32'(bus.out[0]),  32'h1);
      check("clr_rise_30",   32'(bus.rise[0]), 32'h1);

      // Independence across channels after a fresh reset.
      bus.in = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.clr = 4'b0100;
      for (int e = 1; e <= 32; e++) begin
         bus.in = {1'b1, 1'b1, 1'(e % 2), 1'b1};
         tick();
         check($sformatf("ind_tap0_%0d", e), 32'(taps(0)), 32'(ramp(e)));
         check($sformatf("ind_tap3_%0d", e), 32'(taps(3)), 32'(ramp(e)));
         check($sformatf("ind_tap1_%0d", e), 32'(taps(1)), 32'h0);
         check($sformatf("ind_tap2_%0d", e), 32'(taps(2)), 32'h0);
         check($sformatf("ind_out_%0d", e),  32'(bus.out),  (e >= 30) ? 32'h9 : 32'h0);
         check($sformatf("ind_rise_%0d", e), 32'(bus.rise), (e == 30) ? 32'h9 : 32'h0);
         check($sformatf("ind_fall_%0d", e), 32'(bus.fall), 32'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
